micro_gen: RTL

//  Parametrised multi-cycle accumulator CPU; next generation of the lab micro. Generic data and

---
 rtl/micro_gen_pkg.sv | 112 +++++++++++
 rtl/micro_gen_return_stack.sv | 44 ++++
 rtl/micro_gen.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/micro_gen_pkg.sv
// micro_gen_pkg: FSM states, decoded operations and the opcode map
// shared by the micro_gen accumulator CPU and its return stack.
package micro_gen_pkg;

  typedef enum logic [2:0] {
    ST_IF,
    ST_AFD,
    ST_MEM,
    ST_EXWB,
    ST_WR
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_LOAD,
    OP_STORE,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_JUMP,
    OP_JZ,
    OP_JC,
    OP_JN,
    OP_CALL,
    OP_RET
  } op_t;

  typedef struct packed {
    op_t  op;
    logic imm;
  } dec_t;

  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_LOAD   = 8'h01;
  localparam logic [7:0] OPC_LOADI  = 8'h02;
  localparam logic [7:0] OPC_STORE  = 8'h03;
  localparam logic [7:0] OPC_STOREI = 8'h04;
  localparam logic [7:0] OPC_ADD    = 8'h10;
  localparam logic [7:0] OPC_ADDI   = 8'h11;
  localparam logic [7:0] OPC_SUB    = 8'h12;
  localparam logic [7:0] OPC_SUBI   = 8'h13;
  localparam logic [7:0] OPC_AND    = 8'h14;
  localparam logic [7:0] OPC_ANDI   = 8'h15;
  localparam logic [7:0] OPC_OR     = 8'h16;
  localparam logic [7:0] OPC_ORI    = 8'h17;
  localparam logic [7:0] OPC_XOR    = 8'h18;
  localparam logic [7:0] OPC_XORI   = 8'h19;
  localparam logic [7:0] OPC_JUMP   = 8'h20;
  localparam logic [7:0] OPC_JZ     = 8'h21;
  localparam logic [7:0] OPC_JC     = 8'h22;
  localparam logic [7:0] OPC_JN     = 8'h23;
  localparam logic [7:0] OPC_CALL   = 8'h30;
  localparam logic [7:0] OPC_RET    = 8'h31;

  // Unknown opcodes, and CALL/RET without a stack, fall out as NOP.
  function automatic dec_t decode(
    input logic [7:0] opc,
    input logic       stack_en
  );
    dec_t d;
    d.op  = OP_NOP;
    d.imm = 1'b0;
    unique case (1'b1)
      (opc == OPC_LOAD):   d.op = OP_LOAD;
      (opc == OPC_LOADI): begin
        d.op  = OP_LOAD;
        d.imm = 1'b1;
      end
      (opc == OPC_STORE):  d.op = OP_STORE;
      (opc == OPC_STOREI): begin
        d.op  = OP_STORE;
        d.imm = 1'b1;
      end
      (opc == OPC_ADD):    d.op = OP_ADD;
      (opc == OPC_ADDI): begin
        d.op  = OP_ADD;
        d.imm = 1'b1;
      end
      (opc == OPC_SUB):    d.op = OP_SUB;
      (opc == OPC_SUBI): begin
        d.op  = OP_SUB;
        d.imm = 1'b1;
      end
      (opc == OPC_AND):    d.op = OP_AND;
      (opc == OPC_ANDI): begin
        d.op  = OP_AND;
        d.imm = 1'b1;
      end
      (opc == OPC_OR):     d.op = OP_OR;
      (opc == OPC_ORI): begin
        d.op  = OP_OR;
        d.imm = 1'b1;
      end
      (opc == OPC_XOR):    d.op = OP_XOR;
      (opc == OPC_XORI): begin
        d.op  = OP_XOR;
        d.imm = 1'b1;
      end
      (opc == OPC_JUMP):   d.op = OP_JUMP;
      (opc == OPC_JZ):     d.op = OP_JZ;
      (opc == OPC_JC):     d.op = OP_JC;
      (opc == OPC_JN):     d.op = OP_JN;
      (stack_en && opc == OPC_CALL): d.op = OP_CALL;
      (stack_en && opc == OPC_RET):  d.op = OP_RET;
      default: d.op = OP_NOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/micro_gen_return_stack.sv
// micro_gen_return_stack: DEPTH x W LIFO of return addresses.
// Push when full / pop when empty are ignored here; the CPU flags them.
module micro_gen_return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] stack_q [DEPTH];
  logic [PW:0]  sp;
  logic [PW-1:0] top_idx;

  assign full    = (sp == (PW+1)'(DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp[PW-1:0] - PW'(1);
  assign top     = stack_q[top_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + (PW+1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      stack_q[sp[PW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/micro_gen.sv
// micro_gen: multi-cycle accumulator CPU, req/ack data memory.
// Define MICRO_CALL_STACK_EN to add the CALL/RET return stack.
module micro_gen
  import micro_gen_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int IADDR_W     = 8,
  parameter int DADDR_W     = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic               _iClk,
  input  logic               _iResetN,
  input  logic [DATA_W-1:0]  _iInstMemData,
  output logic [IADDR_W-1:0] _oInstMemAddr,
  input  logic [DATA_W-1:0]  _iDataMemRData,
  input  logic               _iDataMemAck,
  output logic               _oDataMemReq,
  output logic               _oDataMemWrite,
  output logic [DADDR_W-1:0] _oDataMemAddr,
  output logic [DATA_W-1:0]  _oDataMemWData,
  output logic               _oStackErr
);

  if (DATA_W < 8 || DADDR_W > DATA_W || IADDR_W > DATA_W ||
      STACK_DEPTH < 2 ||
      (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("micro_gen: unsupported parameter combination");
  end

`ifdef MICRO_CALL_STACK_EN
  localparam logic STACK_EN = 1'b1;
`else
  localparam logic STACK_EN = 1'b0;
`endif

  state_t state;
  state_t state_nxt;

  logic [IADDR_W-1:0] pc;
  logic [7:0]         inst;
  logic [DATA_W-1:0]  arg;
  logic [DATA_W-1:0]  mem;
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  operand;
  logic [DATA_W:0]    alu;
  logic               zf;
  logic               cf;
  logic               nf;
  dec_t               dec;
  logic               is_alu;
  logic               is_store;
  logic               mem_rd;
  logic               take;

  assign dec      = decode(inst, STACK_EN);
  assign operand  = dec.imm ? arg : mem;
  assign is_alu   = dec.op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
  assign is_store = (dec.op == OP_STORE);
  assign mem_rd   = !dec.imm && (is_alu || dec.op == OP_LOAD);

  always_comb begin
    take = 1'b0;
    unique case (dec.op)
      OP_JUMP: take = 1'b1;
      OP_JZ:   take = zf;
      OP_JC:   take = cf;
      OP_JN:   take = nf;
      default: take = 1'b0;
    endcase
  end

  // Bit DATA_W is carry for ADD and borrow for SUB.
  always_comb begin
    alu = '0;
    unique case (dec.op)
      OP_ADD:  alu = {1'b0, acc} + {1'b0, operand};
      OP_SUB:  alu = {1'b0, acc} - {1'b0, operand};
      OP_AND:  alu = {1'b0, acc & operand};
      OP_OR:   alu = {1'b0, acc | operand};
      OP_XOR:  alu = {1'b0, acc ^ operand};
      default: alu = '0;
    endcase
  end

`ifdef MICRO_CALL_STACK_EN
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               stack_err;
  logic [IADDR_W-1:0] ret_addr;

  assign push = (state == ST_MEM) && (dec.op == OP_CALL) && !full;
  assign pop  = (state == ST_MEM) && (dec.op == OP_RET) && !empty;

  micro_gen_return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (IADDR_W)
  ) u_stack (
    .clk       (_iClk),
    .rst_n     (_iResetN),
    .push      (push),
    .pop       (pop),
    .push_data (pc),
    .top       (ret_addr),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge _iClk) begin
    if (!_iResetN) begin
      stack_err <= 1'b0;
    end else if (state == ST_MEM &&
                 ((dec.op == OP_CALL && full) ||
                  (dec.op == OP_RET && empty))) begin
      stack_err <= 1'b1;
    end
  end

  assign _oStackErr = stack_err;
`else
  assign _oStackErr = 1'b0;
`endif

  always_ff @(posedge _iClk) begin
    if (!_iResetN) begin
      state <= ST_IF;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IF:   state_nxt = ST_AFD;
      ST_AFD:  state_nxt = ST_MEM;
      ST_MEM: begin
        if (!_oDataMemReq || _iDataMemAck) begin
          state_nxt = ST_EXWB;
        end
      end
      ST_EXWB: state_nxt = is_store ? ST_WR : ST_IF;
      ST_WR: begin
        if (_iDataMemAck) begin
          state_nxt = ST_IF;
        end
      end
      default: state_nxt = ST_IF;
    endcase
  end

  always_ff @(posedge _iClk) begin
    if (!_iResetN) begin
      pc             <= '0;
      inst           <= '0;
      arg            <= '0;
      mem            <= '0;
      acc            <= '0;
      zf             <= 1'b1;
      cf             <= 1'b0;
      nf             <= 1'b0;
      _oInstMemAddr  <= '0;
      _oDataMemReq   <= 1'b0;
      _oDataMemWrite <= 1'b0;
      _oDataMemAddr  <= '0;
      _oDataMemWData <= '0;
    end else begin
      unique case (state)
        ST_IF: begin
          inst          <= _iInstMemData[7:0];
          _oInstMemAddr <= pc | IADDR_W'(1);
        end
        ST_AFD: begin
          arg            <= _iInstMemData;
          _oDataMemAddr  <= _iInstMemData[DADDR_W-1:0];
          _oDataMemWData <= acc;
          pc             <= pc + IADDR_W'(2);
          if (mem_rd) begin
            _oDataMemReq   <= 1'b1;
            _oDataMemWrite <= 1'b0;
          end
        end
        ST_MEM: begin
          if (_oDataMemReq) begin
            if (_iDataMemAck) begin
              mem          <= _iDataMemRData;
              _oDataMemReq <= 1'b0;
            end
          end else begin
            // pc already points past this instruction
            if (take) begin
              pc <= pc + arg[IADDR_W-1:0];
            end
            if (is_store && dec.imm) begin
              _oDataMemAddr  <= acc[DADDR_W-1:0];
              _oDataMemWData <= arg;
            end
`ifdef MICRO_CALL_STACK_EN
            if (push) begin
              pc <= pc + arg[IADDR_W-1:0];
            end
            if (pop) begin
              pc <= ret_addr;
            end
`endif
          end
        end
        ST_EXWB: begin
          _oInstMemAddr <= pc;
          if (dec.op == OP_LOAD) begin
            acc <= operand;
          end else if (is_alu) begin
            acc <= alu[DATA_W-1:0];
            cf  <= alu[DATA_W];
            zf  <= (alu[DATA_W-1:0] == '0);
            nf  <= alu[DATA_W-1];
          end
          if (is_store) begin
            _oDataMemReq   <= 1'b1;
            _oDataMemWrite <= 1'b1;
          end
        end
        ST_WR: begin
          if (_iDataMemAck) begin
            _oDataMemReq   <= 1'b0;
            _oDataMemWrite <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
